// File: rtl/uart_msg_scheduler_pkg.sv
// Shared definitions for the UART message scheduler.
// Holds the 3-bit state encoding, the default tag base and a helper that
// computes the round-robin search order.
package uart_msg_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_TAG  = 3'd1,
    WAIT_TAG  = 3'd2,
    SEND_DATA = 3'd3,
    WAIT_DATA = 3'd4,
    GAP       = 3'd5
  } state_t;

  // ASCII "a": tag of requester 0, requester i sends TAG_BASE+i
  localparam logic [7:0] TAG_BASE_DEFAULT = 8'h61;

  // Index visited at search step 'step' (1..n) when the previous winner was 'last'
  function automatic logic [1:0] rr_index(input logic [1:0] last, input int step, input int n);
    return 2'((int'(last) + step) % n);
  endfunction

endpackage

// File: rtl/uart_msg_scheduler_arb.sv
// Round-robin arbiter for the UART message scheduler.
// Ports:
//   req   - per-requester request levels
//   last  - index of the previously granted requester
//   gnt   - one-hot grant (all zero when nothing requests)
//   idx   - binary index of the granted requester
//   valid - high when some requester was selected
module rr_arbiter
  import uart_msg_scheduler_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      idx,
  output logic            valid
);

  logic [1:0] cand;

  // Search starts one past the last winner and wraps, so the previous
  // winner is the lowest priority on this round.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = rr_index(last, k, NREQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_msg_scheduler.sv
// UART message scheduler: arbitrates between NREQ requesters and sends a
// two-byte packet (tag, payload) per grant through a uart_tx_8n1-style
// transmitter, followed by GAP_CYCLES idle clocks.
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   req        - per-requester level request, held until gnt
//   req_data   - payload byte of requester i in bits [8i+7:8i]
//   gnt        - one-cycle one-hot pulse when a payload is latched
//   tx_byte    - byte to the transmitter (0 outside SEND/WAIT states)
//   tx_start   - start request to the transmitter
//   tx_ready   - transmitter idle/done
//   busy       - high from grant until the end of the gap
//   cur_id     - index of the requester being served
module uart_msg_scheduler
  import uart_msg_scheduler_pkg::*;
#(
  parameter int         NREQ       = 3,
  parameter logic [7:0] TAG_BASE   = TAG_BASE_DEFAULT,
  parameter int         GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        tx_byte,
  output logic              tx_start,
  input  logic              tx_ready,
  output logic              busy,
  output logic [1:0]        cur_id
);

  localparam logic [1:0]  LAST_INIT = 2'(NREQ - 1);
  localparam logic [15:0] GAP_LAST  = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  state_t          state, next_state;
  logic [1:0]      last_granted;
  logic [7:0]      tag_q, data_q, sel_data;
  logic [15:0]     gap_cnt;
  logic            run_q;
  logic [NREQ-1:0] arb_gnt;
  logic [1:0]      arb_idx;
  logic            arb_valid;
  logic            grant_now;
  logic            gap_last;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .last  (last_granted),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // run_q holds off arbitration for one clock after reset release, so the
  // first grant lands on the second rising edge.
  assign grant_now = (state == IDLE) && run_q && arb_valid && tx_ready;
  assign gap_last  = (gap_cnt == GAP_LAST);
  assign busy      = (state != IDLE);

  // Payload byte of the requester the arbiter is currently selecting
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_idx == 2'(i)) sel_data = req_data[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // SEND states hold tx_start until the transmitter drops tx_ready (it has
  // taken the byte); WAIT states then wait for tx_ready to come back.
  always_comb begin
    next_state = state;
    tx_start   = 1'b0;
    tx_byte    = 8'h00;
    case (state)
      IDLE: if (grant_now) next_state = SEND_TAG;
      SEND_TAG: begin
        tx_start = 1'b1;
        tx_byte  = tag_q;
        if (!tx_ready) next_state = WAIT_TAG;
      end
      WAIT_TAG: begin
        tx_byte = tag_q;
        if (tx_ready) next_state = SEND_DATA;
      end
      SEND_DATA: begin
        tx_start = 1'b1;
        tx_byte  = data_q;
        if (!tx_ready) next_state = WAIT_DATA;
      end
      WAIT_DATA: begin
        tx_byte = data_q;
        if (tx_ready) next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP:     if (gap_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant bookkeeping: tag and payload are captured once at grant and are
  // never touched again until the next grant, whatever req_data does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      gnt          <= '0;
      cur_id       <= '0;
      last_granted <= LAST_INIT;
      tag_q        <= '0;
      data_q       <= '0;
    end else begin
      run_q <= 1'b1;
      gnt   <= grant_now ? arb_gnt : '0;
      if (grant_now) begin
        cur_id       <= arb_idx;
        last_granted <= arb_idx;
        tag_q        <= TAG_BASE + {6'd0, arb_idx};
        data_q       <= sel_data;
      end
    end
  end

  // Gap counter runs only inside GAP and is cleared on the last gap clock,
  // so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          gap_cnt <= '0;
    else if (state == GAP && !gap_last)  gap_cnt <= gap_cnt + 16'd1;
    else                                 gap_cnt <= '0;
  end

endmodule
